// File: rtl/uart_tx_fsm_if.sv
// Handshake bundle between the UART TX frame controller, its byte source and the serializer.
interface uart_tx_fsm_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  ser_done;
  logic                  ser_data;
  logic                  Load;
  logic                  ser_en;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_done, ser_data,
    input  Load, ser_en, TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_done, ser_data,
    output Load, ser_en, TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx_fsm.sv
// UART transmit frame controller: sequences start, serializer data, optional parity and stop
// bits onto a registered idle-high line; clk is the baud clock.
module uart_tx_fsm #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           RST_n,
  uart_tx_fsm_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [DATA_WIDTH-1:0] data_s;
  logic                  par_data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_bit;
  logic                  mux;
  logic                  load_c;
  logic                  ser_en_c;
  logic                  tx_q;
  logic                  busy_q;

  assign data_s  = bus.P_DATA;
  // Data parity and parity type are held separately; their XOR is the parity bit.
  assign par_bit = par_data_q ^ par_typ_q;

  always_comb begin
    next_state = state;
    mux        = 1'b1;
    load_c     = 1'b0;
    ser_en_c   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Data_Valid) begin
          load_c     = 1'b1;
          next_state = START;
        end
      end
      START: begin
        mux        = 1'b0;
        ser_en_c   = 1'b1;
        next_state = DATA;
      end
      DATA: begin
        mux      = bus.ser_data;
        // Shift enable must drop with ser_done so the serializer counter stops at 0.
        ser_en_c = !bus.ser_done;
        if (bus.ser_done) begin
          next_state = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        mux        = par_bit;
        next_state = STOP;
      end
      STOP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state      <= IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      par_data_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
    end else begin
      state  <= next_state;
      tx_q   <= mux;
      busy_q <= (next_state != IDLE);
      if (load_c) begin
        par_data_q <= ^data_s;
        par_en_q   <= bus.PAR_EN;
        par_typ_q  <= bus.PAR_TYP;
      end
    end
  end

  assign bus.Load   = load_c;
  assign bus.ser_en = ser_en_c;
  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm with a behavioural 8-bit serializer and a line-bit scoreboard.
module tb_uart_tx_fsm;

  logic clk   = 1'b0;
  logic RST_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fsm_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_fsm #(.DATA_WIDTH(8)) dut (
    .clk   (clk),
    .RST_n (RST_n),
    .bus   (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          exp_q[$];
  bit          clash_seen = 1'b0;

  // Serializer: bit k presented the cycle after the k-th ser_en, ser_done alongside bit 7.
  logic [7:0] sh;
  logic [2:0] cnt;
  always @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      sh           <= '0;
      cnt          <= '0;
      bus.ser_data <= 1'b0;
      bus.ser_done <= 1'b0;
    end else begin
      bus.ser_done <= 1'b0;
      if (bus.Load) begin
        sh  <= bus.P_DATA;
        cnt <= '0;
      end else if (bus.ser_en) begin
        bus.ser_data <= sh[cnt];
        bus.ser_done <= (cnt == 3'd7);
        cnt          <= cnt + 3'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (RST_n && bus.ser_en && bus.ser_done) clash_seen = 1'b1;
  end

  // Expected line from A+1: idle(1), start, data LSB first, optional parity, stop.
  function automatic void push_frame(input logic [7:0] d, input bit pen, input bit ptyp);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pen) exp_q.push_back((^d) ^ ptyp);
    exp_q.push_back(1'b1);
  endfunction

  task automatic test_reset();
    bus.Data_Valid = 1'b0;
    bus.P_DATA     = '0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    RST_n          = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.TX_OUT, bus.Busy, bus.Load, bus.ser_en} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_outputs: got TX/Busy/Load/ser_en=%b expected 1000",
               {bus.TX_OUT, bus.Busy, bus.Load, bus.ser_en});
    end
    @(negedge clk);
    RST_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.TX_OUT, bus.Busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL idle_after_reset: got TX/Busy=%b expected 10", {bus.TX_OUT, bus.Busy});
    end
  endtask

  task automatic test_parity();
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      bus.P_DATA = 8'hA5; bus.PAR_EN = 1'b1; bus.PAR_TYP = t[0]; bus.Data_Valid = 1'b1;
      #1;
      n_cmp++;
      if (bus.Load !== 1'b1 || bus.Busy !== 1'b0) begin
        n_bad++;
        $display("FAIL par%0d_accept: got Load=%b Busy=%b expected Load=1 Busy=0", t, bus.Load, bus.Busy);
      end
      push_frame(8'hA5, 1'b1, t[0]);
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        bus.Data_Valid = 1'b0;
        #1;
        n_cmp++;
        if (exp_q.size() == 0 || bus.TX_OUT !== exp_q[0]) begin
          n_bad++;
          $display("FAIL par%0d_line c=%0d: got TX_OUT=%b expected %b", t, c, bus.TX_OUT,
                   (exp_q.size() != 0) ? exp_q[0] : 1'bx);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        n_cmp++;
        if (bus.Busy !== (c <= 11) || bus.ser_en !== (c <= 8) || bus.Load !== 1'b0) begin
          n_bad++;
          $display("FAIL par%0d_ctrl c=%0d: got Busy=%b ser_en=%b Load=%b expected %b %b 0",
                   t, c, bus.Busy, bus.ser_en, bus.Load, (c <= 11), (c <= 8));
        end
      end
    end
  endtask

  task automatic test_no_parity();
    @(negedge clk);
    bus.P_DATA = 8'h3C; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b1; bus.Data_Valid = 1'b1;
    #1;
    n_cmp++;
    if (bus.Load !== 1'b1) begin
      n_bad++;
      $display("FAIL nopar_accept: got Load=%b expected 1", bus.Load);
    end
    push_frame(8'h3C, 1'b0, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      bus.Data_Valid = 1'b0;
      bus.PAR_EN     = 1'b1;
      #1;
      if (c <= 11) begin
        n_cmp++;
        if (exp_q.size() == 0 || bus.TX_OUT !== exp_q[0]) begin
          n_bad++;
          $display("FAIL nopar_line c=%0d: got TX_OUT=%b expected %b", c, bus.TX_OUT,
                   (exp_q.size() != 0) ? exp_q[0] : 1'bx);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      n_cmp++;
      if (bus.Busy !== (c <= 10) || bus.ser_en !== (c <= 8)) begin
        n_bad++;
        $display("FAIL nopar_ctrl c=%0d: got Busy=%b ser_en=%b expected %b %b",
                 c, bus.Busy, bus.ser_en, (c <= 10), (c <= 8));
      end
    end
  endtask

  task automatic test_ignore_dv();
    @(negedge clk);
    bus.P_DATA = 8'hA5; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0; bus.Data_Valid = 1'b1;
    #1;
    push_frame(8'hA5, 1'b1, 1'b0);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      bus.Data_Valid = (c == 4);
      if (c == 4) begin
        bus.P_DATA = 8'hFF; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b1;
      end
      #1;
      n_cmp++;
      if (bus.Load !== 1'b0) begin
        n_bad++;
        $display("FAIL ign_load c=%0d: got Load=%b expected 0", c, bus.Load);
      end
      if (c <= 12) begin
        n_cmp++;
        if (exp_q.size() == 0 || bus.TX_OUT !== exp_q[0]) begin
          n_bad++;
          $display("FAIL ign_line c=%0d: got TX_OUT=%b expected %b", c, bus.TX_OUT,
                   (exp_q.size() != 0) ? exp_q[0] : 1'bx);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else begin
        n_cmp++;
        if (bus.Busy !== 1'b0 || bus.TX_OUT !== 1'b1) begin
          n_bad++;
          $display("FAIL ign_no_second c=%0d: got Busy=%b TX_OUT=%b expected 0 1", c, bus.Busy, bus.TX_OUT);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    bus.P_DATA = 8'hA5; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0; bus.Data_Valid = 1'b1;
    @(negedge clk);
    bus.Data_Valid = 1'b0;
    repeat (4) @(negedge clk);
    RST_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.TX_OUT, bus.Busy, bus.ser_en} !== 3'b100) begin
      n_bad++;
      $display("FAIL midrst_outputs: got TX/Busy/ser_en=%b expected 100", {bus.TX_OUT, bus.Busy, bus.ser_en});
    end
    exp_q.delete();
    @(negedge clk);
    RST_n = 1'b1;
    @(negedge clk);
    bus.P_DATA = 8'h01; bus.PAR_EN = 1'b0; bus.Data_Valid = 1'b1;
    #1;
    n_cmp++;
    if (bus.Load !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_accept: got Load=%b expected 1", bus.Load);
    end
    push_frame(8'h01, 1'b0, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      bus.Data_Valid = 1'b0;
      #1;
      n_cmp++;
      if (exp_q.size() == 0 || bus.TX_OUT !== exp_q[0] || bus.Busy !== (c <= 10)) begin
        n_bad++;
        $display("FAIL midrst_frame c=%0d: got TX_OUT=%b Busy=%b expected %b %b", c, bus.TX_OUT, bus.Busy,
                 (exp_q.size() != 0) ? exp_q[0] : 1'bx, (c <= 10));
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic test_back_to_back();
    clash_seen = 1'b0;
    @(negedge clk);
    bus.P_DATA = 8'h55; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.Data_Valid = 1'b1;
    #1;
    n_cmp++;
    if (bus.Load !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_first_load: got Load=%b expected 1", bus.Load);
    end
    push_frame(8'h55, 1'b0, 1'b0);
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c == 12) bus.Data_Valid = 1'b0;
      #1;
      n_cmp++;
      if (bus.Load !== (c == 11)) begin
        n_bad++;
        $display("FAIL b2b_load c=%0d: got Load=%b expected %b", c, bus.Load, (c == 11));
      end
      if (bus.Load) push_frame(8'h55, 1'b0, 1'b0);
      n_cmp++;
      if (exp_q.size() == 0 || bus.TX_OUT !== exp_q[0]) begin
        n_bad++;
        $display("FAIL b2b_line c=%0d: got TX_OUT=%b expected %b", c, bus.TX_OUT,
                 (exp_q.size() != 0) ? exp_q[0] : 1'bx);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      n_cmp++;
      if (bus.Busy !== ((c <= 10) || (c >= 12 && c <= 21))) begin
        n_bad++;
        $display("FAIL b2b_busy c=%0d: got Busy=%b expected %b", c, bus.Busy, ((c <= 10) || (c >= 12 && c <= 21)));
      end
    end
    n_cmp++;
    if (clash_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_ser_en_vs_done: got overlap=%b expected 0", clash_seen);
    end
  endtask

  initial begin
    test_reset();
    test_parity();
    test_no_parity();
    test_ignore_dv();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
